// File: rtl/a0_trace_fifo_if.sv
// Output stream of the a0 trace FIFO: head entry with its valid/ready handshake.
interface a0_trace_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [15:0]           out_stamp;

  modport master (output out_valid, output out_data, output out_stamp, input out_ready);
  modport slave  (input out_valid, input out_data, input out_stamp, output out_ready);
endinterface

// File: rtl/a0_trace_fifo.sv
// a0_trace_fifo: records every change of the CPU a0 register in a first-word-fall-through FIFO
// and flags a halt once a0 stops moving. Define A0_TRACE_TIMESTAMP_EN to stamp each entry with a cycle count.
module a0_trace_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 8,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a0,
  a0_trace_fifo_if.master       bus,
  output logic                  full,
  output logic                  overflow,
  output logic                  halted
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STABLE_CYCLES);
  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_CNT   = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         stable_q, stable_d;
  logic [DATA_WIDTH-1:0] prev_q;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q, count_d;
  logic                  overflow_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic a0_chg;
  logic push_req;
  logic push_acc;
  logic push_drop;
  logic pop;
  logic full_s;
  logic valid_s;

  assign a0_chg    = (a0 != prev_q);
  assign push_req  = en && (state_q != S_IDLE) && a0_chg;
  assign valid_s   = (count_q != '0);
  assign full_s    = (count_q == DEPTH_CNT);
  assign pop       = valid_s && bus.out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_acc  = push_req && (!full_s || pop);
  assign push_drop = push_req && full_s && !pop;

  // FSM and sample register state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      stable_q <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      if (en) begin
        prev_q <= a0;
      end
    end
  end

  // FSM next state and stable-run counter
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    case (state_q)
      S_IDLE: begin
        stable_d = '0;
        if (en) state_d = S_TRACK;
        else    state_d = S_IDLE;
      end
      S_TRACK: begin
        if (!en) begin
          state_d  = S_IDLE;
          stable_d = '0;
        end else if (a0_chg) begin
          stable_d = '0;
        end else if (stable_q == STABLE_LAST) begin
          state_d = S_HALTED;
        end else begin
          stable_d = stable_q + SW'(1);
        end
      end
      S_HALTED: begin
        if (!en) begin
          state_d  = S_IDLE;
          stable_d = '0;
        end else if (a0_chg) begin
          state_d  = S_TRACK;
          stable_d = '0;
        end else begin
          state_d = S_HALTED;
        end
      end
      default: begin
        state_d  = S_IDLE;
        stable_d = '0;
      end
    endcase
  end

  // FSM outputs
  always_comb begin
    halted = (state_q == S_HALTED);
  end

  // FIFO occupancy next value
  always_comb begin
    case ({push_acc, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push_acc) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // FIFO data storage
  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      mem_q[wr_ptr_q] <= a0;
    end
  end

`ifdef A0_TRACE_TIMESTAMP_EN
  logic [15:0] cyc_q;
  logic [15:0] stamp_q [DEPTH];

  // Free-running cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= 16'h0000;
    end else begin
      cyc_q <= cyc_q + 16'h0001;
    end
  end

  // Per-entry stamp storage
  always_ff @(posedge clk) begin
    if (!rst && push_acc) begin
      stamp_q[wr_ptr_q] <= cyc_q;
    end
  end

  assign bus.out_stamp = stamp_q[rd_ptr_q];
`else
  assign bus.out_stamp = 16'h0000;
`endif

  assign bus.out_valid = valid_s;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign full          = full_s;
  assign overflow      = overflow_q;
endmodule
